// File: rtl/row_enc_pkg.sv
// Shared definitions for the row encoder: packet prefixes, FSM state encoding
// and the builder for the fixed timer-wrap alarm packet.
package row_enc_pkg;

   localparam logic [1:0] PFX_DATA  = 2'b00;
   localparam logic [1:0] PFX_TS    = 2'b01;
   localparam logic [1:0] PFX_ALARM = 2'b10;
   localparam logic [1:0] PFX_RUN   = 2'b11;

   localparam int unsigned PKT_MAX_IDX_W = 9;
   localparam int unsigned PKT_MAX_W     = 1 << PKT_MAX_IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PUSH = 2'd1,
      ST_HOLD = 2'd2
   } enc_state_t;

   // Alarm packet is the ALARM prefix above an all-zero payload of pay_w bits;
   // callers size-cast the result down to their packet width.
   function automatic logic [PKT_MAX_W-1:0] ALARM_WORD(input int unsigned pay_w);
      logic [PKT_MAX_W-1:0] word;
      word = '0;
      word[PKT_MAX_IDX_W'(pay_w) +: 2] = PFX_ALARM;
      return word;
   endfunction

endpackage

// File: rtl/enc_sync_fifo.sv
// Output FIFO of the row encoder: first-word fall-through from a register
// array, with simultaneous push and pop accepted while full.
module enc_sync_fifo
   import row_enc_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic             o_wr_ready,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_rd_valid
);

   localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;

   logic w_full;
   logic w_wr_acc;
   logic w_rd_acc;

   assign w_full     = (r_count == FULL_CNT);
   assign o_rd_valid = (r_count != '0);
   assign w_rd_acc   = i_rd_en & o_rd_valid;
   // A pop in the same cycle frees the slot the push needs.
   assign o_wr_ready = ~w_full | w_rd_acc;
   assign w_wr_acc   = i_wr_en & o_wr_ready;
   assign o_rd_data  = o_rd_valid ? r_mem[r_rptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wptr] <= i_wr_data;
   end

endmodule

// File: rtl/row_encoder_np.sv
// N-pixel row compression encoder: emits distinct rows, suppresses repeats,
// timestamps pattern breaks, flags timer wrap. Define RUN_COUNT_EN for run-count packets.
module row_encoder_np
   import row_enc_pkg::*;
#(
   parameter int unsigned N_PIX      = 10,
   parameter int unsigned PIX_W      = 3,
   parameter int unsigned TS_W       = 30,
   parameter int unsigned RUN_W      = 16,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     data_valid,
   input  logic [N_PIX*PIX_W-1:0]   pixel_in,
   input  logic [TS_W-1:0]          tik_tok,
   output logic [N_PIX*PIX_W+1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     fifo_ovf,
   output logic                     in_overrun
);

   localparam int unsigned      PAY_W     = N_PIX * PIX_W;
   localparam int unsigned      PKT_W     = PAY_W + 2;
   localparam logic [PKT_W-1:0] ALARM_PKT = PKT_W'(ALARM_WORD(PAY_W));

   enc_state_t       r_state;
   enc_state_t       w_state_nxt;
   logic             r_dv_d;
   logic [PAY_W-1:0] r_row;
   logic [TS_W-1:0]  r_ts;
   logic             r_pend_ts;
   logic             r_pend_data;
   logic             r_pend_alarm;
   logic             r_fifo_ovf;
   logic             r_in_overrun;

   logic             w_edge;
   logic             w_same;
   logic             w_wrap;
   logic             w_blocked;
   logic             w_accept;
   logic             w_drop;
   logic             w_set_data;
   logic             w_set_ts;
   logic             w_load_row;
   logic             w_pend_cnt;
   logic [RUN_W-1:0] w_cnt_val;
   logic             w_drain_any;
   logic             w_drain_go;
   logic             w_drain_ts;
   logic             w_drain_data;
   logic             w_drain_alarm;
   logic             w_wr_ready;
   logic [PKT_W-1:0] w_drain_pkt;

   assign w_edge    = data_valid & ~r_dv_d;
   assign w_same    = (pixel_in == r_row);
   assign w_wrap    = &tik_tok;
   // Only row-related packets block a new sample; a pending alarm never does.
   assign w_blocked = w_pend_cnt | r_pend_ts | r_pend_data;
   assign w_accept  = w_edge & ~w_blocked;
   assign w_drop    = w_edge & w_blocked;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_PUSH;
            ST_PUSH: if (w_same)  w_state_nxt = ST_HOLD;
            ST_HOLD: if (!w_same) w_state_nxt = ST_PUSH;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_set_data = 1'b0;
      w_set_ts   = 1'b0;
      w_load_row = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               w_set_data = 1'b1;
               w_load_row = 1'b1;
            end
            ST_PUSH: begin
               w_set_data = ~w_same;
               w_load_row = ~w_same;
            end
            ST_HOLD: begin
               w_set_ts   = ~w_same;
               w_set_data = ~w_same;
               w_load_row = ~w_same;
            end
            default: ;
         endcase
      end
   end

`ifdef RUN_COUNT_EN
   logic [RUN_W-1:0] r_cnt;
   logic             r_pend_cnt;
   logic             w_drain_cnt;

   assign w_drain_cnt = w_drain_go & r_pend_cnt;
   assign w_pend_cnt  = r_pend_cnt;
   assign w_cnt_val   = r_cnt;

   // A run count accompanies every break timestamp.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pend_cnt <= 1'b0;
      else        r_pend_cnt <= w_set_ts | (r_pend_cnt & ~w_drain_cnt);
   end

   always_ff @(posedge clk) begin
      if (w_accept && w_same) begin
         if (r_state == ST_PUSH)
            r_cnt <= RUN_W'(1);
         else if (r_state == ST_HOLD && r_cnt != '1)
            r_cnt <= r_cnt + 1'b1;
      end
   end
`else
   assign w_pend_cnt = 1'b0;
   assign w_cnt_val  = '0;
`endif

   // Drain priority CNT, TS, DATA, ALARM keeps the break packets in order.
   assign w_drain_any   = w_pend_cnt | r_pend_ts | r_pend_data | r_pend_alarm;
   assign w_drain_go    = w_drain_any & w_wr_ready;
   assign w_drain_ts    = w_drain_go & ~w_pend_cnt & r_pend_ts;
   assign w_drain_data  = w_drain_go & ~w_pend_cnt & ~r_pend_ts & r_pend_data;
   assign w_drain_alarm = w_drain_go & ~w_pend_cnt & ~r_pend_ts & ~r_pend_data & r_pend_alarm;

   always_comb begin
      w_drain_pkt = ALARM_PKT;
      if (w_pend_cnt)
         w_drain_pkt = {PFX_RUN, PAY_W'(w_cnt_val)};
      else if (r_pend_ts)
         w_drain_pkt = {PFX_TS, PAY_W'(r_ts)};
      else if (r_pend_data)
         w_drain_pkt = {PFX_DATA, r_row};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dv_d       <= 1'b0;
         r_row        <= '0;
         r_pend_ts    <= 1'b0;
         r_pend_data  <= 1'b0;
         r_pend_alarm <= 1'b0;
         r_fifo_ovf   <= 1'b0;
         r_in_overrun <= 1'b0;
      end else begin
         r_dv_d       <= data_valid;
         r_pend_ts    <= w_set_ts   | (r_pend_ts    & ~w_drain_ts);
         r_pend_data  <= w_set_data | (r_pend_data  & ~w_drain_data);
         r_pend_alarm <= w_wrap     | (r_pend_alarm & ~w_drain_alarm);
         if (w_load_row)               r_row        <= pixel_in;
         if (w_drop)                   r_in_overrun <= 1'b1;
         if (w_drop && !w_wr_ready)    r_fifo_ovf   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_set_ts) r_ts <= tik_tok;
   end

   assign fifo_ovf   = r_fifo_ovf;
   assign in_overrun = r_in_overrun;

   enc_sync_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_wr_en    (w_drain_any),
      .i_wr_data  (w_drain_pkt),
      .o_wr_ready (w_wr_ready),
      .i_rd_en    (out_ready),
      .o_rd_data  (out_data),
      .o_rd_valid (out_valid)
   );

endmodule

// File: tb/tb_row_encoder_np.sv
// Directed bench for row_encoder_np: scenario tasks with hand-computed packets.
module tb_row_encoder_np;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_valid;
   logic [29:0] pixel_in;
   logic [29:0] tik_tok;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        fifo_ovf;
   logic        in_overrun;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] got_q[$];

   always #5 clk = ~clk;

   row_encoder_np #(
      .N_PIX(10), .PIX_W(3), .TS_W(30), .RUN_W(16), .FIFO_DEPTH(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_valid (data_valid),
      .pixel_in   (pixel_in),
      .tik_tok    (tik_tok),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_ovf   (fifo_ovf),
      .in_overrun (in_overrun)
   );

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      data_valid = 1'b0;
      pixel_in   = '0;
      tik_tok    = '0;
      out_ready  = 1'b1;
      rst_n      = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      got_q.delete();
   endtask

   task automatic send(input logic [29:0] row, input logic [29:0] ts, input int gap);
      pixel_in   = row;
      tik_tok    = ts;
      data_valid = 1'b1;
      step(1);
      data_valid = 1'b0;
      tik_tok    = '0;
      step(gap);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 00000000", out_data); end
      n_tests++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_ovf got %b want 0", fifo_ovf); end
      n_tests++; if (in_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_in_overrun got %b want 0", in_overrun); end
   endtask

   task automatic test_latency_distinct();
      logic [31:0] exp_q[$];
      do_reset();
      pixel_in   = 30'h1234567;
      data_valid = 1'b1;
      step(1);
      data_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle1 out_valid got %b want 0", out_valid); end
      step(1);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_cycle2 out_valid got %b want 1", out_valid); end
      n_tests++; if (out_data !== 32'h01234567) begin n_fail++; $display("FAIL lat_cycle2 out_data got %h want 01234567", out_data); end
      step(1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_cycle3 out_valid got %b want 0", out_valid); end
      send(30'h0ABCDEF, 30'h0, 6);
      exp_q = '{32'h01234567, 32'h00ABCDEF};
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL distinct_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL distinct_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL distinct_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_run_break();
      logic [31:0] exp_q[$];
      do_reset();
      send(30'h0000155, 30'h0, 4);
      send(30'h0000155, 30'h0, 4);
      send(30'h0000155, 30'h0, 4);
      send(30'h00002AA, 30'h100, 8);
      exp_q.push_back(32'h00000155);
`ifdef RUN_COUNT_EN
      exp_q.push_back(32'hC0000002);
`endif
      exp_q.push_back(32'h40000100);
      exp_q.push_back(32'h000002AA);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL run_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL run_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL run_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap_hold();
      logic [31:0] exp_q[$];
      do_reset();
      send(30'h0000007, 30'h0, 4);
      send(30'h0000007, 30'h0, 4);
      tik_tok = 30'h3FFFFFFF;
      step(1);
      tik_tok = 30'h0;
      step(3);
      send(30'h0000038, 30'h200, 8);
      exp_q.push_back(32'h00000007);
      exp_q.push_back(32'h80000000);
`ifdef RUN_COUNT_EN
      exp_q.push_back(32'hC0000001);
`endif
      exp_q.push_back(32'h40000200);
      exp_q.push_back(32'h00000038);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wrap_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL wrap_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_wrap_simul();
      logic [31:0] exp_q[$];
      do_reset();
      send(30'h0001000, 30'h3FFFFFFF, 5);
      send(30'h0002000, 30'h3FFFFFFF, 6);
      exp_q = '{32'h00001000, 32'h80000000, 32'h00002000, 32'h80000000};
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL simul_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL simul_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL simul_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] exp_q[$];
      logic [29:0] row;
      do_reset();
      out_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         row = 30'(i * 30'h111);
         send(row, 30'h0, 5);
      end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
      n_tests++; if (out_data !== 32'h00000111) begin n_fail++; $display("FAIL bp_head got %h want 00000111", out_data); end
      n_tests++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_early got %b want 0", fifo_ovf); end
      n_tests++; if (in_overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun_early got %b want 0", in_overrun); end
      send(30'h0000AAA, 30'h0, 5);
      n_tests++; if (fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf got %b want 1", fifo_ovf); end
      n_tests++; if (in_overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun got %b want 1", in_overrun); end
      tik_tok = 30'h3FFFFFFF;
      step(3);
      tik_tok = 30'h0;
      step(1);
      out_ready = 1'b1;
      step(16);
      for (int i = 1; i <= 9; i++) exp_q.push_back(32'(i * 32'h111));
      exp_q.push_back(32'h80000000);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL bp_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_tests++; if (fifo_ovf !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_sticky got %b want 1", fifo_ovf); end
   endtask

   task automatic test_overrun();
      logic [31:0] exp_q[$];
      do_reset();
      send(30'h0000011, 30'h0, 4);
      send(30'h0000011, 30'h0, 4);
      send(30'h0000022, 30'h300, 1);
      send(30'h0000033, 30'h0, 8);
      n_tests++; if (in_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_in_overrun got %b want 1", in_overrun); end
      n_tests++; if (fifo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovr_fifo_ovf got %b want 0", fifo_ovf); end
      // Dropped sample must leave the stored row as 0x22, so 0x22 again is a repeat.
      send(30'h0000022, 30'h0, 5);
      send(30'h0000033, 30'h400, 8);
      exp_q.push_back(32'h00000011);
`ifdef RUN_COUNT_EN
      exp_q.push_back(32'hC0000001);
`endif
      exp_q.push_back(32'h40000300);
      exp_q.push_back(32'h00000022);
`ifdef RUN_COUNT_EN
      exp_q.push_back(32'hC0000001);
`endif
      exp_q.push_back(32'h40000400);
      exp_q.push_back(32'h00000033);
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovr_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL ovr_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [31:0] exp_q[$];
      do_reset();
      out_ready = 1'b0;
      send(30'h0000101, 30'h0, 3);
      send(30'h0000202, 30'h0, 3);
      send(30'h0000303, 30'h0, 3);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
      out_ready = 1'b1;
      step(1);
      rst_n = 1'b0;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", out_valid); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL mid_rst_data got %h want 00000000", out_data); end
      step(2);
      rst_n = 1'b1;
      step(3);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid got %b want 0", out_valid); end
      got_q.delete();
      send(30'h0000303, 30'h0, 8);
      exp_q = '{32'h00000303};
      n_tests++;
      if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_tests++;
         if (i >= got_q.size()) begin n_fail++; $display("FAIL mid_pkt%0d got none want %h", i, exp_q[i]); end
         else if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_pkt%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      data_valid = 1'b0;
      pixel_in   = '0;
      tik_tok    = '0;
      out_ready  = 1'b1;
      test_reset();
      test_latency_distinct();
      test_run_break();
      test_wrap_hold();
      test_wrap_simul();
      test_back_pressure();
      test_overrun();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1);
   end

endmodule
